// File: rtl/ram_dual_fifo_ctrl.sv
// Controller that turns a 2x8 dual-bank sync-read RAM into an 8-deep FIFO of
// (a,b) pairs, with a registered output holding slot in front of the consumer.
module ram_dual_fifo_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data_a,
  input  logic [WIDTH-1:0] in_data_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data_a,
  output logic [WIDTH-1:0] out_data_b,
  output logic [3:0]       count,
  output logic             ram_we,
  output logic [2:0]       ram_addr_a,
  output logic [2:0]       ram_addr_b,
  output logic [WIDTH-1:0] ram_din_a,
  output logic [WIDTH-1:0] ram_din_b,
  input  logic [WIDTH-1:0] ram_dout_a,
  input  logic [WIDTH-1:0] ram_dout_b
);

  logic [3:0]       wptr_q, wptr_d;
  logic [3:0]       rptr_q, rptr_d;
  logic [3:0]       count_q, count_d;
  logic             rd_pend_q, rd_pend_d;
  logic             prio_q, prio_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_a_q, out_data_a_d;
  logic [WIDTH-1:0] out_data_b_q, out_data_b_d;

  logic full, empty, wr_req, rd_req, contested, wr_gnt, rd_gnt;

  // One RAM op per cycle: arbitrate write vs read, alternating on contention.
  always_comb begin
    full      = (count_q == 4'd8);
    empty     = (count_q == 4'd0);
    wr_req    = in_valid && !full;
    rd_req    = !empty && !rd_pend_q && !out_valid_q;
    contested = wr_req && rd_req;
    wr_gnt    = wr_req && !(rd_req && prio_q);
    rd_gnt    = rd_req && !(wr_req && !prio_q);
  end

  always_comb begin
    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    count_d      = count_q;
    rd_pend_d    = rd_pend_q;
    prio_d       = prio_q;
    out_valid_d  = out_valid_q;
    out_data_a_d = out_data_a_q;
    out_data_b_d = out_data_b_q;

    if (wr_gnt) begin
      wptr_d  = wptr_q + 4'd1;
      count_d = count_q + 4'd1;
    end else if (rd_gnt) begin
      rptr_d    = rptr_q + 4'd1;
      count_d   = count_q - 4'd1;
      rd_pend_d = 1'b1;
    end

    if (contested) prio_d = !prio_q;

    // RAM read data is valid the cycle after the read grant; capture it here.
    if (rd_pend_q) begin
      out_data_a_d = ram_dout_a;
      out_data_b_d = ram_dout_b;
      out_valid_d  = 1'b1;
      rd_pend_d    = 1'b0;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= '0;
      rd_pend_q    <= 1'b0;
      prio_q       <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_a_q <= '0;
      out_data_b_q <= '0;
    end else begin
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      count_q      <= count_d;
      rd_pend_q    <= rd_pend_d;
      prio_q       <= prio_d;
      out_valid_q  <= out_valid_d;
      out_data_a_q <= out_data_a_d;
      out_data_b_q <= out_data_b_d;
    end
  end

  // in_ready depends only on state so the producer may wait on it combinationally.
  always_comb begin
    in_ready   = !full && !(rd_req && prio_q);
    ram_we     = wr_gnt;
    ram_addr_a = wr_gnt ? wptr_q[2:0] : rptr_q[2:0];
    ram_addr_b = ram_addr_a;
    ram_din_a  = in_data_a;
    ram_din_b  = in_data_b;
    out_valid  = out_valid_q;
    out_data_a = out_data_a_q;
    out_data_b = out_data_b_q;
    count      = count_q;
  end

endmodule

// File: tb/tb_ram_dual_fifo_ctrl.sv
// Bench for ram_dual_fifo_ctrl: behavioural dual-bank RAM plus a scoreboard
// fed on accepted input pairs and drained by an output monitor.
module tb_ram_dual_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data_a = '0;
  logic [7:0] in_data_b = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data_a, out_data_b;
  logic [3:0] count;
  logic       ram_we;
  logic [2:0] ram_addr_a, ram_addr_b;
  logic [7:0] ram_din_a, ram_din_b;
  logic [7:0] ram_dout_a, ram_dout_b;

  logic [7:0] mem_a [8];
  logic [7:0] mem_b [8];

  int passed = 0;
  int total = 0;
  int pops = 0;
  logic [15:0] exp_q [$];

  always #5 clk = ~clk;

  ram_dual_fifo_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data_a(in_data_a), .in_data_b(in_data_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data_a(out_data_a), .out_data_b(out_data_b),
    .count(count), .ram_we(ram_we),
    .ram_addr_a(ram_addr_a), .ram_addr_b(ram_addr_b),
    .ram_din_a(ram_din_a), .ram_din_b(ram_din_b),
    .ram_dout_a(ram_dout_a), .ram_dout_b(ram_dout_b)
  );

  // Sync-read RAM: write or registered read, one op per cycle.
  always @(posedge clk) begin
    if (ram_we) begin
      mem_a[ram_addr_a] <= ram_din_a;
      mem_b[ram_addr_b] <= ram_din_b;
    end else begin
      ram_dout_a <= mem_a[ram_addr_a];
      ram_dout_b <= mem_b[ram_addr_b];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask

  // Producer-side scoreboard feed: every accepted pair is expected later, in order.
  always @(negedge clk) begin
    if (!rst && in_valid && in_ready) exp_q.push_back({in_data_a, in_data_b});
  end

  // Consumer-side monitor.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      pops++;
      if (exp_q.size() == 0) check("unexpected_output", {out_data_a, out_data_b}, 32'hFFFF_FFFF);
      else check("out_pair", {out_data_a, out_data_b}, exp_q.pop_front());
    end
    if (!rst) check("addr_b_eq_a", ram_addr_b, ram_addr_a);
  end

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_count", count, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_ram_we", ram_we, 0);
    check("rst_out_data", {out_data_a, out_data_b}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    bit done = 0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid && count == 0) begin done = 1; break; end
    end
    check(name, done, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [10:0] we_tab;
    int p0;
    bit got;

    // 1: reset
    do_reset();

    // 2: fill with consumer stalled
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_data_a = 8'h10 + 8'(i);
      in_data_b = 8'h20 + 8'(i);
      got = 0;
      for (int k = 0; k < 30; k++) begin
        @(negedge clk);
        if (in_ready) got = 1;
        @(posedge clk); #1;
        if (got) break;
      end
      if (i < 9) check("fill_accept", got, 1);
      else check("fill_reject_10th", got, 0);
    end
    @(negedge clk);
    check("full_count", count, 8);
    check("full_in_ready", in_ready, 0);
    check("full_out_valid", out_valid, 1);
    check("full_out_data", {out_data_a, out_data_b}, 16'h1020);
    check("full_queue_depth", exp_q.size(), 9);
    @(posedge clk); #1;

    // 3: drain everything, read pointer wraps
    p0 = pops;
    drain("drain_done", 100);
    check("drain_pops", pops - p0, 9);
    check("drain_count", count, 0);

    // 4: contention with both sides active
    do_reset();
    we_tab = 11'b11011101110;
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      in_data_a = 8'h40 + 8'(i);
      in_data_b = 8'h80 + 8'(i);
      @(negedge clk);
      if (i < 11) check("contend_we_seq", ram_we, we_tab[10-i]);
      if (i == 11) check("contend_count_c11", count, 5);
      @(posedge clk); #1;
    end
    drain("contend_drain", 200);

    // 5: single-push latency
    do_reset();
    out_ready = 1'b1;
    p0 = pops;
    in_valid = 1'b1; in_data_a = 8'h55; in_data_b = 8'h66;
    @(negedge clk);
    check("t5_c0_we", ram_we, 1);
    check("t5_c0_addr", ram_addr_a, 0);
    @(posedge clk); #1; in_valid = 1'b0;
    @(negedge clk);
    check("t5_c1_we", ram_we, 0);
    check("t5_c1_addr", ram_addr_a, 0);
    check("t5_c1_count", count, 1);
    @(negedge clk);
    check("t5_c2_out_valid", out_valid, 0);
    @(negedge clk);
    check("t5_c3_out_valid", out_valid, 1);
    @(posedge clk); #1;
    check("t5_pops", pops - p0, 1);

    // 6: reset while the read is in flight
    do_reset();
    in_valid = 1'b1; in_data_a = 8'h77; in_data_b = 8'h88;
    @(posedge clk); #1; in_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("t6_rst_out_valid", out_valid, 0);
    check("t6_rst_count", count, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("t6_no_stale_valid", out_valid, 0);
    end
    @(posedge clk); #1;
    p0 = pops;
    in_valid = 1'b1; in_data_a = 8'h99; in_data_b = 8'hAA;
    @(posedge clk); #1; in_valid = 1'b0;
    drain("t6_drain", 20);
    check("t6_pops", pops - p0, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
